// File: rtl/hazard_ctrl_if.sv
// Hazard controller pipeline-side signal bundle.
// master: pipeline datapath (drives hazard inputs, consumes enables/flushes).
// slave:  hazard_ctrl.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       IFID_Rs;
   logic [4:0]       IFID_Rt;
   logic             IFID_UsesRt;
   logic             IDEX_MemRead;
   logic [4:0]       IDEX_Rt;
   logic             Branch_Taken;
   logic             MD_Start;
   logic             MD_Div;
   logic             Stall_Clr;
   logic             PC_Write;
   logic             IFID_Write;
   logic             IDEX_Write;
   logic             IFID_Flush;
   logic             IDEX_Flush;
   logic             MD_Busy;
   logic             MD_Done;
   logic [CNT_W-1:0] Stall_Cycles;

   modport master (
      output IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
             Branch_Taken, MD_Start, MD_Div, Stall_Clr,
      input  PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush,
             MD_Busy, MD_Done, Stall_Cycles
   );

   modport slave (
      input  IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
             Branch_Taken, MD_Start, MD_Div, Stall_Clr,
      output PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush,
             MD_Busy, MD_Done, Stall_Cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core (ID/EX).
// Generates PC/IF-ID/ID-EX write enables and flushes for load-use stalls and
// taken branches, sequences the multi-cycle mult/div unit, and counts stall
// cycles (saturating).
// Optional feature macro: HAZARD_MULDIV_EN enables the mult/div sequencer;
// without it MD_Start/MD_Div are ignored and MD_Busy/MD_Done stay 0.
module hazard_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 16
) (
   input logic           clk,
   input logic           rst,
   hazard_ctrl_if.slave  hz
);

   logic             load_use;
   logic             ex_hold;
   logic             md_done;
   logic             pc_write;
   logic [CNT_W-1:0] stall_q;

`ifdef HAZARD_MULDIV_EN
   localparam int MAX_LOAD = ((DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES) - 2;
   localparam int CW       = (MAX_LOAD > 1) ? $clog2(MAX_LOAD + 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

   md_state_t     state;
   logic [CW-1:0] cnt;
   logic          md_done_q;

   // Mult/div sequencer: start -> BUSY countdown -> one DONE cycle -> IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         md_done_q <= 1'b0;
      end else begin
         md_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (hz.MD_Start) begin
                  cnt   <= hz.MD_Div ? CW'(DIV_CYCLES - 2) : CW'(MUL_CYCLES - 2);
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state     <= DONE;
                  md_done_q <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Hold is released while rst is asserted, even if MD_Start is still high.
   always_comb begin
      ex_hold = ~rst & (((state == IDLE) & hz.MD_Start) | (state == BUSY));
      md_done = md_done_q;
   end
`else
   logic unused_md;

   // Mult/div sequencer absent: EX is never held.
   always_comb begin
      ex_hold   = 1'b0;
      md_done   = 1'b0;
      unused_md = hz.MD_Start ^ hz.MD_Div;
   end
`endif

   // Hazard decode and enable/flush generation; EX hold > branch > load-use.
   always_comb begin
      load_use = hz.IDEX_MemRead & (hz.IDEX_Rt != 5'd0) &
                 ((hz.IDEX_Rt == hz.IFID_Rs) |
                  (hz.IFID_UsesRt & (hz.IDEX_Rt == hz.IFID_Rt)));
      pc_write        = ~ex_hold & ~(load_use & ~hz.Branch_Taken);
      hz.PC_Write     = pc_write;
      hz.IFID_Write   = pc_write;
      hz.IDEX_Write   = ~ex_hold;
      hz.IFID_Flush   = hz.Branch_Taken & ~ex_hold;
      hz.IDEX_Flush   = (hz.Branch_Taken | load_use) & ~ex_hold;
      hz.MD_Busy      = ex_hold;
      hz.MD_Done      = md_done;
      hz.Stall_Cycles = stall_q;
   end

   // Saturating stall-cycle counter; clear takes precedence over increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (hz.Stall_Clr) begin
         stall_q <= '0;
      end else if (!pc_write && (stall_q != '1)) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

endmodule
